// File: rtl/e_sd_dat_rx.sv
// ---------------------------------------------------------------------------
// e_sd_dat_rx : SD/SDIO host read-data receiver (SD clock domain).
//
// Waits for the start bit on the used DAT lines, deserialises one block into
// bytes (MSB first, 1-bit or 4-bit bus), pushes every byte into the receive
// FIFO, then checks the per-line CRC16-CCITT and the end bit.
//
// Ports:
//   clk          SD clock; DAT lines sampled on the rising edge
//   rst          synchronous active-high reset
//   rx_start     one-cycle pulse arming the receiver for one block
//   rx_abort     synchronous abort back to IDLE (wins over rx_start)
//   bus_width_4  1 = DAT[3:0] used, 0 = DAT[0] only (latched on rx_start)
//   block_size   bytes per block, 1..2048 (latched on rx_start)
//   timeout_val  start-bit timeout in cycles
//   dat_in       registered DAT[3:0] from the pads
//   push         one-cycle byte strobe to the FIFO
//   push_data    received byte, valid while push=1
//   dat_end      one-cycle pulse after the end bit has been sampled
//   crc_err      sticky CRC mismatch on any used line
//   end_bit_err  sticky end bit seen as 0 on any used line
//   timeout_err  sticky start-bit timeout
//   busy         high in every state except IDLE
// ---------------------------------------------------------------------------
module e_sd_dat_rx #(
  parameter int TO_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx_start,
  input  logic            rx_abort,
  input  logic            bus_width_4,
  input  logic [11:0]     block_size,
  input  logic [TO_W-1:0] timeout_val,
  input  logic [3:0]      dat_in,
  output logic            push,
  output logic [7:0]      push_data,
  output logic            dat_end,
  output logic            crc_err,
  output logic            end_bit_err,
  output logic            timeout_err,
  output logic            busy
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_CRC  = 3'd3,
    ST_END  = 3'd4
  } state_t;

  state_t           state_r;
  logic             w4_r;
  logic [11:0]      blk_r;
  logic [11:0]      byte_cnt_r;
  logic [2:0]       bit_cnt_r;
  logic [3:0]       crc_cnt_r;
  logic [TO_W-1:0]  to_cnt_r;
  logic [7:0]       shift_r;
  logic [3:0][15:0] crc_r;
  logic             crc_mis_r;

  logic [3:0]       used_s;
  logic [3:0]       crc_top_s;
  logic             start_s;
  logic             byte_last_s;
  logic             crc_bit_mis_s;
  logic             end_bad_s;
  logic             to_hit_s;
  logic [7:0]       next_byte_s;
  logic [TO_W-1:0]  to_inc_s;
  logic [3:0][15:0] crc_upd_s;
  logic [3:0][15:0] crc_shl_s;

  // One serial step of CRC16-CCITT (x^16 + x^12 + x^5 + 1)
  function automatic logic [15:0] crc16_bit(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // Decode of the current DAT sample against the latched bus width
  always_comb begin
    used_s      = w4_r ? 4'b1111 : 4'b0001;
    start_s     = ((dat_in & used_s) == 4'b0000);
    byte_last_s = w4_r ? (bit_cnt_r == 3'd1) : (bit_cnt_r == 3'd7);
    next_byte_s = w4_r ? {shift_r[3:0], dat_in} : {shift_r[6:0], dat_in[0]};
    // Counter is bumped first and then compared; 0 trips on the first miss
    to_inc_s    = to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
    to_hit_s    = (to_inc_s == timeout_val) || (timeout_val == {TO_W{1'b0}});
    for (int i = 0; i < 4; i++) begin
      crc_top_s[i] = crc_r[i][15];
      crc_upd_s[i] = crc16_bit(crc_r[i], dat_in[i]);
      crc_shl_s[i] = {crc_r[i][14:0], 1'b0};
    end
    // Received CRC is compared bit by bit against the MSB of the shifted CRC
    crc_bit_mis_s = |((dat_in ^ crc_top_s) & used_s);
    end_bad_s     = |(~dat_in & used_s);
  end

  // Receive FSM with registered FIFO strobes and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      w4_r        <= 1'b0;
      blk_r       <= 12'd0;
      byte_cnt_r  <= 12'd0;
      bit_cnt_r   <= 3'd0;
      crc_cnt_r   <= 4'd0;
      to_cnt_r    <= {TO_W{1'b0}};
      shift_r     <= 8'h00;
      crc_r       <= {64{1'b0}};
      crc_mis_r   <= 1'b0;
      push        <= 1'b0;
      push_data   <= 8'h00;
      dat_end     <= 1'b0;
      crc_err     <= 1'b0;
      end_bit_err <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      push    <= 1'b0;
      dat_end <= 1'b0;
      if (rx_abort) begin
        state_r <= ST_IDLE;
        busy    <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (rx_start && (block_size != 12'd0)) begin
              blk_r       <= block_size;
              w4_r        <= bus_width_4;
              crc_err     <= 1'b0;
              end_bit_err <= 1'b0;
              timeout_err <= 1'b0;
              to_cnt_r    <= {TO_W{1'b0}};
              state_r     <= ST_WAIT;
              busy        <= 1'b1;
            end
          end
          ST_WAIT: begin
            if (start_s) begin
              crc_r      <= {64{1'b0}};
              bit_cnt_r  <= 3'd0;
              byte_cnt_r <= 12'd0;
              state_r    <= ST_DATA;
            end else if (to_hit_s) begin
              to_cnt_r    <= to_inc_s;
              timeout_err <= 1'b1;
              state_r     <= ST_IDLE;
              busy        <= 1'b0;
            end else begin
              to_cnt_r <= to_inc_s;
            end
          end
          ST_DATA: begin
            crc_r   <= crc_upd_s;
            shift_r <= next_byte_s;
            if (byte_last_s) begin
              push      <= 1'b1;
              push_data <= next_byte_s;
              bit_cnt_r <= 3'd0;
              if (byte_cnt_r == (blk_r - 12'd1)) begin
                crc_cnt_r <= 4'd0;
                crc_mis_r <= 1'b0;
                state_r   <= ST_CRC;
              end else begin
                byte_cnt_r <= byte_cnt_r + 12'd1;
              end
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end
          ST_CRC: begin
            crc_r     <= crc_shl_s;
            crc_mis_r <= crc_mis_r | crc_bit_mis_s;
            if (crc_cnt_r == 4'd15) begin
              crc_err <= crc_err | crc_mis_r | crc_bit_mis_s;
              state_r <= ST_END;
            end else begin
              crc_cnt_r <= crc_cnt_r + 4'd1;
            end
          end
          ST_END: begin
            if (end_bad_s) begin
              end_bit_err <= 1'b1;
            end
            dat_end <= 1'b1;
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end
          default: begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_e_sd_dat_rx.sv
// ---------------------------------------------------------------------------
// tb_e_sd_dat_rx : directed + randomised bench for e_sd_dat_rx.
// A byte-level model builds the DAT sample stream (start, data, per-line
// CRC16, end bit) and the expected pushes / dat_end timing and flags.
// ---------------------------------------------------------------------------
module tb_e_sd_dat_rx;

  localparam int TO_W = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_start;
  logic        rx_abort;
  logic        bus_width_4;
  logic [11:0] block_size;
  logic [15:0] timeout_val;
  logic [3:0]  dat_in;
  logic        push;
  logic [7:0]  push_data;
  logic        dat_end;
  logic        crc_err;
  logic        end_bit_err;
  logic        timeout_err;
  logic        busy;

  e_sd_dat_rx #(.TO_W(TO_W)) dut (
    .clk(clk), .rst(rst), .rx_start(rx_start), .rx_abort(rx_abort),
    .bus_width_4(bus_width_4), .block_size(block_size), .timeout_val(timeout_val),
    .dat_in(dat_in), .push(push), .push_data(push_data), .dat_end(dat_end),
    .crc_err(crc_err), .end_bit_err(end_bit_err), .timeout_err(timeout_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         nvec = 0;
  int         nmis = 0;
  logic [7:0] pd_q[$];
  int         pc_q[$];
  int         de_cyc_q[$];
  logic [2:0] de_flag_q[$];
  logic [7:0] byte_q[$];
  logic [3:0] samp_q[$];

  // Edge counter: after rising edge N, cyc == N
  always @(posedge clk) cyc <= cyc + 1;

  // Record FIFO pushes and dat_end events with the edge that produced them
  always @(negedge clk) begin
    if (push === 1'b1) begin
      pd_q.push_back(push_data);
      pc_q.push_back(cyc);
    end
    if (dat_end === 1'b1) begin
      de_cyc_q.push_back(cyc);
      de_flag_q.push_back({crc_err, end_bit_err, timeout_err});
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return (c << 1) ^ (((c[15] ^ b) == 1'b1) ? 16'h1021 : 16'h0000);
  endfunction

  // Build the DAT sample stream for byte_q: start, data, CRC (optionally
  // overridden / LSB-flipped per line), end bit (0 on lines in ebad)
  task automatic build(input bit w4, input int n, input logic [3:0] flip,
                       input logic [3:0] ebad, input bit fixed, input logic [15:0] fcrc);
    logic [15:0] lc [4];
    logic [3:0]  s;
    logic [7:0]  bv;
    samp_q.delete();
    for (int l = 0; l < 4; l++) lc[l] = 16'h0000;
    s = 4'b0000;
    if (!w4) s[3:1] = 3'($urandom);
    samp_q.push_back(s);
    for (int k = 0; k < n; k++) begin
      bv = byte_q[k];
      if (w4) begin
        samp_q.push_back(bv[7:4]);
        samp_q.push_back(bv[3:0]);
        for (int b = 7; b >= 0; b--) lc[b % 4] = crc_step(lc[b % 4], bv[b]);
      end else begin
        for (int b = 7; b >= 0; b--) begin
          s = {3'($urandom), bv[b]};
          samp_q.push_back(s);
          lc[0] = crc_step(lc[0], bv[b]);
        end
      end
    end
    if (fixed) lc[0] = fcrc;
    for (int l = 0; l < 4; l++) lc[l][0] = lc[l][0] ^ flip[l];
    for (int j = 15; j >= 0; j--) begin
      for (int l = 0; l < 4; l++) s[l] = lc[l][j];
      if (!w4) s[3:1] = 3'($urandom);
      samp_q.push_back(s);
    end
    s = ~ebad;
    if (!w4) s[3:1] = 3'($urandom);
    samp_q.push_back(s);
  endtask

  task automatic run_block(input string tag, input bit w4, input int n, input logic [3:0] flip,
                           input logic [3:0] ebad, input bit fixed, input logic [15:0] fcrc,
                           input int mid);
    int         per, e0, ps, ds;
    logic [3:0] used;
    build(w4, n, flip, ebad, fixed, fcrc);
    used = w4 ? 4'hF : 4'h1;
    per  = w4 ? 2 : 8;
    ps   = pd_q.size();
    ds   = de_cyc_q.size();
    @(negedge clk);
    block_size = 12'(n); bus_width_4 = w4; rx_start = 1'b1; dat_in = 4'hF;
    @(negedge clk);
    rx_start = 1'b0;
    @(negedge clk);
    e0 = 0;
    for (int i = 0; i < samp_q.size(); i++) begin
      @(negedge clk);
      dat_in = samp_q[i];
      if (i == 0) e0 = cyc + 1;
      if (mid > 0 && i == mid) begin
        rx_start = 1'b1; block_size = 12'd1; bus_width_4 = ~w4;
      end else begin
        rx_start = 1'b0;
      end
    end
    @(negedge clk);
    dat_in = 4'hF; rx_start = 1'b0;
    repeat (4) @(negedge clk);
    check($sformatf("%s_push_count", tag), pd_q.size() - ps, n);
    for (int k = 0; k < n && (ps + k) < pd_q.size(); k++) begin
      check($sformatf("%s_data%0d", tag, k), pd_q[ps + k], byte_q[k]);
      check($sformatf("%s_cyc%0d", tag, k), pc_q[ps + k] - e0, per * (k + 1));
    end
    check($sformatf("%s_dat_end_count", tag), de_cyc_q.size() - ds, 1);
    if (de_cyc_q.size() > ds) begin
      check($sformatf("%s_dat_end_cyc", tag), de_cyc_q[ds] - e0, per * n + 17);
      check($sformatf("%s_flags", tag), de_flag_q[ds],
            {|(flip & used), |(ebad & used), 1'b0});
    end
    check($sformatf("%s_busy_after", tag), busy, 1'b0);
  endtask

  initial begin
    int         ent, hit, ps, ds;
    bit         w4;
    int         n;
    logic [3:0] fl, eb;

    rst = 1'b1; rx_start = 1'b0; rx_abort = 1'b0; bus_width_4 = 1'b0;
    block_size = 12'd0; timeout_val = 16'd1000; dat_in = 4'hF;
    repeat (3) @(negedge clk);
    check("reset_outputs", {push, push_data, dat_end, crc_err, end_bit_err, timeout_err, busy}, 14'h0);
    rst = 1'b0;

    // 1-bit, two bytes
    byte_q = '{8'hA5, 8'h3C};
    run_block("b1_two", 1'b0, 2, 4'h0, 4'h0, 1'b0, 16'h0, 0);

    // 1-bit, 512 x 0xFF with known CRC, then with its LSB flipped
    byte_q.delete();
    for (int k = 0; k < 512; k++) byte_q.push_back(8'hFF);
    run_block("b1_512", 1'b0, 512, 4'h0, 4'h0, 1'b1, 16'h7FA1, 0);
    run_block("b1_512_bad", 1'b0, 512, 4'h1, 4'h0, 1'b1, 16'h7FA1, 0);

    // 4-bit, four bytes, DAT2 end bit low
    byte_q = '{8'h12, 8'h34, 8'h56, 8'h78};
    run_block("b4_four", 1'b1, 4, 4'h0, 4'b0100, 1'b0, 16'h0, 0);

    // Randomised blocks
    for (int r = 0; r < 4; r++) begin
      w4 = 1'($urandom);
      n  = $urandom_range(1, 24);
      fl = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      eb = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      byte_q.delete();
      for (int k = 0; k < n; k++) byte_q.push_back(8'($urandom));
      run_block($sformatf("rand%0d", r), w4, n, fl, eb, 1'b0, 16'h0, 0);
    end

    // rx_start during DATA is ignored
    byte_q = '{8'h5A, 8'hC3, 8'h0F};
    run_block("mid_start", 1'b0, 3, 4'h0, 4'h0, 1'b0, 16'h0, 5);

    // Start-bit timeout, 10 and 0
    for (int t = 0; t < 2; t++) begin
      timeout_val = (t == 0) ? 16'd10 : 16'd0;
      ps = pd_q.size(); ds = de_cyc_q.size(); hit = -1;
      @(negedge clk);
      block_size = 12'd5; bus_width_4 = 1'b1; rx_start = 1'b1; dat_in = 4'hF;
      ent = cyc + 1;
      @(negedge clk);
      rx_start = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (hit < 0 && timeout_err === 1'b1) begin
          hit = cyc;
          check($sformatf("to%0d_busy_drop", t), busy, 1'b0);
        end
        @(negedge clk);
      end
      check($sformatf("to%0d_cycle", t), hit - ent, (t == 0) ? 10 : 1);
      check($sformatf("to%0d_no_push", t), pd_q.size() - ps, 0);
      check($sformatf("to%0d_no_dat_end", t), de_cyc_q.size() - ds, 0);
    end
    timeout_val = 16'd1000;

    // rx_start with block_size 0: ignored, flags untouched
    @(negedge clk);
    block_size = 12'd0; rx_start = 1'b1;
    @(negedge clk);
    rx_start = 1'b0;
    check("bs0_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    check("bs0_busy_later", busy, 1'b0);
    check("bs0_flag_kept", timeout_err, 1'b1);

    // Abort mid-data, with a simultaneous rx_start
    byte_q.delete();
    for (int k = 0; k < 4; k++) byte_q.push_back(8'($urandom));
    build(1'b0, 4, 4'h0, 4'h0, 1'b0, 16'h0);
    ps = pd_q.size(); ds = de_cyc_q.size();
    @(negedge clk);
    block_size = 12'd4; bus_width_4 = 1'b0; rx_start = 1'b1; dat_in = 4'hF;
    @(negedge clk);
    rx_start = 1'b0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      dat_in = samp_q[i];
    end
    @(negedge clk);
    rx_abort = 1'b1; rx_start = 1'b1; dat_in = samp_q[11];
    @(negedge clk);
    rx_abort = 1'b0; rx_start = 1'b0; dat_in = 4'hF;
    check("abort_busy", busy, 1'b0);
    repeat (40) @(negedge clk);
    check("abort_pushes", pd_q.size() - ps, 1);
    check("abort_no_dat_end", de_cyc_q.size() - ds, 0);
    check("abort_busy_later", busy, 1'b0);

    // Reset after 3 bytes of a 16-byte block, then a full clean block
    byte_q.delete();
    for (int k = 0; k < 16; k++) byte_q.push_back(8'($urandom));
    build(1'b0, 16, 4'h0, 4'h0, 1'b0, 16'h0);
    ps = pd_q.size(); ds = de_cyc_q.size();
    @(negedge clk);
    block_size = 12'd16; bus_width_4 = 1'b0; rx_start = 1'b1; dat_in = 4'hF;
    @(negedge clk);
    rx_start = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      dat_in = samp_q[i];
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_outputs", {push, push_data, dat_end, crc_err, end_bit_err, timeout_err, busy}, 14'h0);
    rst = 1'b0; dat_in = 4'hF;
    repeat (30) @(negedge clk);
    check("rst_pushes", pd_q.size() - ps, 3);
    check("rst_no_dat_end", de_cyc_q.size() - ds, 0);
    run_block("after_rst", 1'b0, 16, 4'h0, 4'h0, 1'b0, 16'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
